// File: rtl/pem_mix_pkg.sv
// Shared constants and types for the PEM lock-in mixer: widths, table geometry,
// ROM latency, product slice indices and the control state enum.
package pem_mix_pkg;

  localparam int ADDR_W      = 9;
  localparam int TBL_DEPTH   = 512;
  localparam int FRAME_EDGES = 10;
  localparam int ROM_LAT     = 2;
  localparam int WAVE_W      = 48;
  localparam int REF_W       = 16;

  localparam int PROD_W      = REF_W + WAVE_W;
  localparam int MIX_LSB     = 17;
  localparam int MIX_MSB     = PROD_W - 1;
  localparam int MIX_W       = MIX_MSB - MIX_LSB + 1;

  localparam int EDGE_CNT_W  = $clog2(FRAME_EDGES + 1);
  localparam int SAMP_CNT_W  = $clog2(TBL_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } mix_state_e;

endpackage

// File: rtl/pem_mix_mult.sv
// Registered signed REF_W x WAVE_W multiplier; emits product[MIX_MSB:MIX_LSB]
// with its valid carried alongside.
module pem_mix_mult
  import pem_mix_pkg::*;
(
  input  logic                     alg_clk,
  input  logic                     alg_rst,
  input  logic                     in_valid,
  input  logic signed [REF_W-1:0]  ref_smp,
  input  logic signed [WAVE_W-1:0] wave_word,
  output logic [MIX_W-1:0]         mix,
  output logic                     mix_valid
);

  logic signed [PROD_W-1:0] prod;

  // Both operands are sign-extended to the full product width before multiplying.
  assign prod = PROD_W'(ref_smp) * PROD_W'(wave_word);

  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      mix       <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= in_valid;
      if (in_valid) begin
        mix <= MIX_W'(prod >>> MIX_LSB);
      end
    end
  end

endmodule

// File: rtl/pem_lockin_mixer.sv
// PEM frame-locked wave-table addressing and I/Q mixing of the ref sample stream.
// Frame-length supervision (period_err) is compiled in with PEM_PERIOD_CHECK_EN.
module pem_lockin_mixer
  import pem_mix_pkg::*;
(
  input  logic              alg_clk,
  input  logic              alg_rst,
  input  logic              enable,
  input  logic [REF_W-1:0]  ref_dat,
  input  logic              ref_dat_valid,
  input  logic              pem_edge,
  output logic              wave_dat_req,
  output logic [ADDR_W-1:0] wave_addr,
  input  logic [WAVE_W-1:0] wave_dat_sine,
  input  logic [WAVE_W-1:0] wave_dat_cosine,
  output logic [MIX_W-1:0]  mix_sine,
  output logic [MIX_W-1:0]  mix_cosine,
  output logic              mix_valid,
  output logic              locked,
  output logic              period_err
);

  mix_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_d, addr_inc;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  locked_d;
  logic                  issue;
  logic                  edge_smp, frame_end;
`ifdef PEM_PERIOD_CHECK_EN
  logic [SAMP_CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic                  err_d;
`endif

  assign edge_smp  = ref_dat_valid & pem_edge;
  assign frame_end = edge_smp && (edge_cnt_q == EDGE_CNT_W'(FRAME_EDGES));
  assign addr_inc  = (wave_addr == ADDR_W'(TBL_DEPTH - 1)) ? '0 : wave_addr + ADDR_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    addr_d     = wave_addr;
    edge_cnt_d = edge_cnt_q;
    locked_d   = locked;
    issue      = 1'b0;
`ifdef PEM_PERIOD_CHECK_EN
    samp_cnt_d = samp_cnt_q;
    err_d      = 1'b0;
`endif
    if (!enable) begin
      state_d    = ST_IDLE;
      edge_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (edge_smp) begin
            state_d    = ST_RUN;
            issue      = 1'b1;
            addr_d     = '0;
            edge_cnt_d = EDGE_CNT_W'(1);
`ifdef PEM_PERIOD_CHECK_EN
            samp_cnt_d = SAMP_CNT_W'(1);
`endif
          end
        end
        ST_RUN: begin
          if (ref_dat_valid) begin
            issue = 1'b1;
            if (frame_end) begin
              addr_d     = '0;
              edge_cnt_d = EDGE_CNT_W'(1);
              locked_d   = 1'b1;
`ifdef PEM_PERIOD_CHECK_EN
              samp_cnt_d = SAMP_CNT_W'(1);
              if (samp_cnt_q != SAMP_CNT_W'(TBL_DEPTH)) begin
                err_d    = 1'b1;
                locked_d = 1'b0;
              end
`endif
            end
`ifdef PEM_PERIOD_CHECK_EN
            // A full table has gone by with no restart edge: drop lock and re-arm.
            else if (samp_cnt_q == SAMP_CNT_W'(TBL_DEPTH)) begin
              issue      = 1'b0;
              err_d      = 1'b1;
              locked_d   = 1'b0;
              edge_cnt_d = '0;
              state_d    = ST_ARM;
            end
`endif
            else begin
              addr_d = addr_inc;
              if (pem_edge) begin
                edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
              end
`ifdef PEM_PERIOD_CHECK_EN
              samp_cnt_d = samp_cnt_q + SAMP_CNT_W'(1);
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [ROM_LAT:0] vld_sr;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      state_q    <= ST_IDLE;
      wave_addr  <= '0;
      edge_cnt_q <= '0;
      locked     <= 1'b0;
      vld_sr     <= '0;
    end else begin
      state_q    <= state_d;
      wave_addr  <= addr_d;
      edge_cnt_q <= edge_cnt_d;
      locked     <= locked_d;
      vld_sr     <= {vld_sr[ROM_LAT-1:0], issue};
    end
  end

  assign wave_dat_req = vld_sr[0];

`ifdef PEM_PERIOD_CHECK_EN
  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      samp_cnt_q <= '0;
      period_err <= 1'b0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      period_err <= err_d;
    end
  end
`else
  assign period_err = 1'b0;
`endif

  // Ref sample delayed ROM_LAT+1 so it meets the table words returned for its request.
  logic [REF_W-1:0] ref_sr [ROM_LAT+1];

  // NOTE: data-only pipeline is left unreset; the reset valid bits already mask its contents.
  always_ff @(posedge alg_clk) begin
    ref_sr[0] <= ref_dat;
    for (int i = 1; i <= ROM_LAT; i++) begin
      ref_sr[i] <= ref_sr[i-1];
    end
  end

  logic sin_valid, cos_valid;

  pem_mix_mult u_mult_sine (
    .alg_clk   (alg_clk),
    .alg_rst   (alg_rst),
    .in_valid  (vld_sr[ROM_LAT]),
    .ref_smp   ($signed(ref_sr[ROM_LAT])),
    .wave_word ($signed(wave_dat_sine)),
    .mix       (mix_sine),
    .mix_valid (sin_valid)
  );

  pem_mix_mult u_mult_cosine (
    .alg_clk   (alg_clk),
    .alg_rst   (alg_rst),
    .in_valid  (vld_sr[ROM_LAT]),
    .ref_smp   ($signed(ref_sr[ROM_LAT])),
    .wave_word ($signed(wave_dat_cosine)),
    .mix       (mix_cosine),
    .mix_valid (cos_valid)
  );

  assign mix_valid = sin_valid & cos_valid;

endmodule
